// File: rtl/hi_ssp_serializer_if.sv
// hi_ssp_serializer_if: sample handshake between the HF demodulator and the SSP serializer
interface hi_ssp_serializer_if;
    logic [7:0] sample_d;
    logic       sample_valid;
    logic       sample_ready;
    modport master (output sample_d, sample_valid, input sample_ready);
    modport slave  (input sample_d, sample_valid, output sample_ready);
endinterface

// File: rtl/hi_ssp_serializer.sv
// hi_ssp_serializer: FIFO-buffered MSB-first SSP byte serializer; HI_SSP_SERIALIZER_OVFCNT_EN enables the drop counter
module hi_ssp_serializer #(
    parameter int CLK_DIV    = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                pck0,
    input  logic                rst,
    hi_ssp_serializer_if.slave  s,
    output logic                ssp_clk,
    output logic                ssp_frame,
    output logic                ssp_din,
    output logic [7:0]          overflow_cnt
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t        state, state_n;
    logic [DW-1:0] div_cnt, div_n;
    logic          boundary;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic [7:0]    shreg, shreg_n;
    logic [2:0]    bit_idx, bit_n;
    assign div_n = boundary ? '0 : div_cnt + 1'b1;
    assign boundary = div_cnt == DIV_MAX;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = wr_ptr == rd_ptr;
    assign s.sample_ready = !full && !rst;
    assign push = s.sample_valid && s.sample_ready;
    assign pop = boundary && !empty && (state == IDLE || bit_idx == 3'd0);
    // Free-running bit-clock divider; ssp_clk falls exactly when div_cnt wraps to 0
    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            ssp_clk <= 1'b0;
        end else begin
            div_cnt <= div_n;
            ssp_clk <= div_n >= DIV_HALF;
        end
    end
    // FIFO pointers carry an extra wrap bit so full and empty are distinguishable
    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    // Sample storage needs no reset; only entries between the pointers are ever read
    always_ff @(posedge pck0) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s.sample_d;
    end
    // Shifter state register
    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_n;
            shreg   <= shreg_n;
            bit_idx <= bit_n;
        end
    end
    // Next state: advance only at bit boundaries, reloading back-to-back when data is waiting
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        bit_n   = bit_idx;
        if (pop) begin
            state_n = SHIFT;
            shreg_n = mem[rd_ptr[AW-1:0]];
            bit_n   = 3'd7;
        end else if (boundary && state == SHIFT && bit_idx != 3'd0) begin
            shreg_n = {shreg[6:0], 1'b0};
            bit_n   = bit_idx - 3'd1;
        end else if (boundary) begin
            state_n = IDLE;
        end
    end
    // Outputs decode registered state only, so reset clears them immediately
    always_comb begin
        ssp_din   = (state == SHIFT) ? shreg[7] : 1'b0;
        ssp_frame = (state == SHIFT) ? bit_idx == 3'd7 : 1'b0;
    end
`ifdef HI_SSP_SERIALIZER_OVFCNT_EN
    logic drop;
    assign drop = s.sample_valid && full;
    // Saturating count of samples refused while the FIFO was full
    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) overflow_cnt <= '0;
        else if (drop && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
    end
`else
    assign overflow_cnt = '0;
`endif
endmodule

// File: doc/hi_ssp_serializer.md
HI_SSP_SERIALIZER -- requirements
Module: hi_ssp_serializer

Interface
REQ-001 Parameter CLK_DIV, default 8, pck0 cycles per ssp_clk period; even, >= 4.
REQ-002 Parameter FIFO_DEPTH, default 4, sample FIFO entries; power of two, >= 2.
REQ-003 Clock and reset: one clock, pck0; reset rst, asynchronous, active-high.
REQ-004 pck0  input  1  system clock (48 MHz), all logic on posedge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 sample_d  input  8  demodulated sample from the active HF mode.
REQ-007 sample_valid  input  1  sample_d is valid this cycle.
REQ-008 sample_ready  output  1  FIFO accepts a sample this cycle.
REQ-009 ssp_clk  output  1  SSP bit clock to the ARM.
REQ-010 ssp_frame  output  1  frame marker, high during the first bit of each byte.
REQ-011 ssp_din  output  1  serial data to the ARM, MSB first.
REQ-012 overflow_cnt  output  8  count of dropped samples.

Function
REQ-013 A push SHALL occur on a pck0 edge with sample_valid=1 and sample_ready=1; sample_ready SHALL be 1 exactly when the FIFO is not full and rst=0.
REQ-014 A sample offered with sample_valid=1 while the FIFO is full SHALL be dropped, and the FIFO contents SHALL stay unchanged.
REQ-015 div_cnt SHALL count 0..CLK_DIV-1 and wrap continuously; ssp_clk SHALL be registered, low for div_cnt < CLK_DIV/2 and high otherwise, and SHALL run continuously after reset.
REQ-016 A bit boundary SHALL be the cycle div_cnt wraps to 0, which is the ssp_clk falling edge; ssp_din and ssp_frame SHALL change only at bit boundaries so the ARM samples on the rising edge.
REQ-017 The FSM SHALL have two states. IDLE: ssp_din=0, ssp_frame=0. SHIFT: shreg[7] drives ssp_din, and bit_idx counts 7 down to 0.
REQ-018 At a boundary in IDLE with the FIFO non-empty, the FSM SHALL pop the head into shreg, set bit_idx=7 and enter SHIFT.
REQ-019 At a boundary in SHIFT with bit_idx>0, the FSM SHALL shift shreg left one and decrement bit_idx.
REQ-020 At a boundary in SHIFT with bit_idx=0, the FSM SHALL pop and reload with no gap if the FIFO is non-empty, otherwise enter IDLE.
REQ-021 ssp_frame SHALL be 1 exactly while in SHIFT with bit_idx=7, i.e. one ssp_clk period per byte.
REQ-022 Latency: a sample pushed into an empty FIFO in IDLE SHALL drive its MSB on ssp_din at the next bit boundary, at most CLK_DIV pck0 cycles after the push.
REQ-023 A pop and a push in the same cycle SHALL both take effect, leaving occupancy unchanged; when full, the pop frees the slot only for the following cycle.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH, and full/empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-025 While rst=1, all outputs SHALL be 0: ssp_clk, ssp_frame, ssp_din, sample_ready and overflow_cnt.
REQ-026 While rst=1, the FSM SHALL be IDLE, div_cnt=0 and the FIFO empty.
REQ-027 Reset asserted mid-byte SHALL abandon the byte and clear ssp_frame/ssp_din immediately (asynchronously); no partial byte SHALL be resumed.
REQ-028 After rst deasserts, sample_ready SHALL be 1 on the first pck0 edge.

Configuration
REQ-029 Macro HI_SSP_SERIALIZER_OVFCNT_EN: when defined, overflow_cnt SHALL increment by 1 per dropped sample and saturate at 255; when undefined, overflow_cnt SHALL be constant 0 and the counter logic SHALL be absent.

Verification
REQ-030 CLK_DIV=8, reset, push 0xA5 -> at the next boundary ssp_frame=1 for 8 pck0 cycles, and ssp_din reads 1,0,1,0,0,1,0,1 on ssp_clk rising edges.
REQ-031 Push 0x3C and 0xFF back-to-back -> 16 contiguous bit periods with no idle gap, and ssp_frame pulses at bits 0 and 8.
REQ-032 Hold sample_valid=1 with FIFO_DEPTH=4 -> sample_ready drops after 4 pushes (plus pops in flight), and with the macro defined overflow_cnt counts the drops, saturating at 255 after 300 drops.
REQ-033 Assert rst at bit 3 of 0x81 -> ssp_frame=0, ssp_din=0 and ssp_clk=0 immediately; after release the next pushed byte 0x42 is sent complete with ssp_frame.
REQ-034 Push on the same cycle as a pop with FIFO holding 2 -> occupancy stays 2, and byte order is preserved (0x11, 0x22, 0x33 out in order).
REQ-035 Macro undefined, overflow forced -> overflow_cnt stays 0, and dropped samples never appear on ssp_din.
